// File: rtl/reg_alu_seq.sv
// -----------------------------------------------------------------------------
// reg_alu_seq
//   Command sequencer for the register-file/ALU datapath. LOAD (immediate ->
//   register) and ALU (rA op rB -> rDst) commands are queued in a small FIFO.
//   The sequencer retires them one at a time by driving the datapath's
//   sel/wr/op and address lines, and it records ALU carries in a sticky flag.
//
//   Parameters
//     QDEPTH  command FIFO entries (power of two, 2..16)
//     DW      datapath word width
//
//   Ports
//     clk           rising-edge clock
//     reset         synchronous, active-low reset
//     cmd_valid     command offered
//     cmd_ready     FIFO can accept a command (not full)
//     cmd_kind      0 = LOAD immediate, 1 = ALU op
//     cmd_op        ALU op code (ignored for LOAD)
//     cmd_a/cmd_b   source register addresses
//     cmd_dst       destination register address
//     cmd_imm       immediate data for LOAD
//     dp_sel        0 = write d_in, 1 = write ALU result
//     dp_wr         register-file write strobe
//     dp_op         ALU op
//     dp_rd_addr_a  read port A address
//     dp_rd_addr_b  read port B address
//     dp_wr_addr    write address
//     dp_d_in       immediate data
//     dp_alu_cout   combinational ALU carry-out from the datapath
//     busy          sequencer active or commands queued
//     done          one-cycle pulse per retired command
//     carry_flag    sticky OR of ALU carries since reset/clear
//     carry_clr     clears carry_flag (a simultaneous set wins)
//     retired_cnt   (RETIRE_CNT_EN only) count of retired commands, wraps
//
//   Optional feature: define RETIRE_CNT_EN to add the retired_cnt output.
// -----------------------------------------------------------------------------
module reg_alu_seq #(
    parameter int QDEPTH = 4,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_kind,
    input  logic [1:0]    cmd_op,
    input  logic [2:0]    cmd_a,
    input  logic [2:0]    cmd_b,
    input  logic [2:0]    cmd_dst,
    input  logic [DW-1:0] cmd_imm,
    output logic          dp_sel,
    output logic          dp_wr,
    output logic [1:0]    dp_op,
    output logic [2:0]    dp_rd_addr_a,
    output logic [2:0]    dp_rd_addr_b,
    output logic [2:0]    dp_wr_addr,
    output logic [DW-1:0] dp_d_in,
    input  logic          dp_alu_cout,
    output logic          busy,
    output logic          done,
    output logic          carry_flag,
    input  logic          carry_clr
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]   retired_cnt
`endif
);

    localparam int            AW       = $clog2(QDEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(QDEPTH);

    typedef struct packed {
        logic          kind;
        logic [1:0]    op;
        logic [2:0]    a;
        logic [2:0]    b;
        logic [2:0]    dst;
        logic [DW-1:0] imm;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    cmd_t          fifo_mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    cmd_t          new_cmd, head_cmd, cmd_q, cur_cmd;
    logic          push, pop;

    assign new_cmd   = '{kind: cmd_kind, op: cmd_op, a: cmd_a, b: cmd_b,
                         dst: cmd_dst, imm: cmd_imm};
    assign head_cmd  = fifo_mem[rd_ptr];
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    // The sequencer only takes a new command from IDLE, so at most one
    // command is in flight and consecutive writes are always separated.
    assign pop       = (state_q == IDLE) && (count != '0);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(QDEPTH) wide, so +1 wraps modulo depth.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // count says it was written, so clearing it would add logic for nothing.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= new_cmd;
    end

    // Command register holds the in-flight command through EXEC/WRITE.
    always_ff @(posedge clk) begin
        if (!reset)   cmd_q <= '0;
        else if (pop) cmd_q <= head_cmd;
    end

    // Command the datapath will see next cycle: the head being popped, or the
    // command already in flight.
    assign cur_cmd = pop ? head_cmd : cmd_q;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = head_cmd.kind ? EXEC : WRITE;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output logic. Datapath controls are registered, so the values for
    // the next cycle are derived from the next state.
    // ---------------------------------------------------------------------
    logic          sel_d, wr_d;
    logic [1:0]    op_d;
    logic [2:0]    rd_a_d, rd_b_d, wr_addr_d;
    logic [DW-1:0] d_in_d;

    // NOTE: every output of this block gets a default first (hold or zero),
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_d     = dp_sel;
        wr_d      = 1'b0;
        op_d      = dp_op;
        rd_a_d    = dp_rd_addr_a;
        rd_b_d    = dp_rd_addr_b;
        wr_addr_d = dp_wr_addr;
        d_in_d    = dp_d_in;
        case (state_d)
            EXEC: begin
                // Present operands one cycle ahead of the write so the
                // register-file read and ALU result settle first.
                rd_a_d    = cur_cmd.a;
                rd_b_d    = cur_cmd.b;
                op_d      = cur_cmd.op;
                wr_addr_d = cur_cmd.dst;
                sel_d     = 1'b1;
            end
            WRITE: begin
                wr_d      = 1'b1;
                sel_d     = cur_cmd.kind;
                wr_addr_d = cur_cmd.dst;
                // LOAD has no EXEC phase; ALU keeps the EXEC operands and
                // leaves d_in at its previous value.
                if (!cur_cmd.kind) d_in_d = cur_cmd.imm;
            end
            default: ;
        endcase
    end

    logic carry_set;
    assign carry_set = (state_q == WRITE) && cmd_q.kind && dp_alu_cout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_sel       <= 1'b0;
            dp_wr        <= 1'b0;
            dp_op        <= '0;
            dp_rd_addr_a <= '0;
            dp_rd_addr_b <= '0;
            dp_wr_addr   <= '0;
            dp_d_in      <= '0;
            done         <= 1'b0;
            carry_flag   <= 1'b0;
        end else begin
            dp_sel       <= sel_d;
            dp_wr        <= wr_d;
            dp_op        <= op_d;
            dp_rd_addr_a <= rd_a_d;
            dp_rd_addr_b <= rd_b_d;
            dp_wr_addr   <= wr_addr_d;
            dp_d_in      <= d_in_d;
            done         <= (state_q == WRITE);
            // A carry arriving in the same cycle as a clear takes priority.
            if (carry_set)      carry_flag <= 1'b1;
            else if (carry_clr) carry_flag <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE) || (count != '0);

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)    retired_cnt <= '0;
        else if (done) retired_cnt <= retired_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_alu_seq
//   Self-checking bench for reg_alu_seq. A transaction-level model (queue of
//   accepted commands plus a per-command timeline) predicts every output each
//   cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_alu_seq;

    localparam int QDEPTH = 4;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_kind;
    logic [1:0]    cmd_op;
    logic [2:0]    cmd_a, cmd_b, cmd_dst;
    logic [DW-1:0] cmd_imm;
    logic          dp_sel, dp_wr;
    logic [1:0]    dp_op;
    logic [2:0]    dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr;
    logic [DW-1:0] dp_d_in;
    logic          dp_alu_cout, busy, done, carry_flag, carry_clr;
`ifdef RETIRE_CNT_EN
    logic [15:0]   retired_cnt;
`endif

    always #5 clk = ~clk;

    reg_alu_seq #(.QDEPTH(QDEPTH), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kind     (cmd_kind),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_dst      (cmd_dst),
        .cmd_imm      (cmd_imm),
        .dp_sel       (dp_sel),
        .dp_wr        (dp_wr),
        .dp_op        (dp_op),
        .dp_rd_addr_a (dp_rd_addr_a),
        .dp_rd_addr_b (dp_rd_addr_b),
        .dp_wr_addr   (dp_wr_addr),
        .dp_d_in      (dp_d_in),
        .dp_alu_cout  (dp_alu_cout),
        .busy         (busy),
        .done         (done),
        .carry_flag   (carry_flag),
        .carry_clr    (carry_clr)
`ifdef RETIRE_CNT_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: queue of accepted commands and a timeline for the
    // command in flight (t = cycles since it left the queue; an ALU command
    // spends t=1 reading operands and t=2 writing, a LOAD writes at t=1;
    // the cycle after the write is a done/idle cycle).
    // ---------------------------------------------------------------------
    typedef struct {
        bit        kind;
        bit [1:0]  op;
        bit [2:0]  a, b, dst;
        bit [15:0] imm;
    } tcmd_t;

    tcmd_t     m_q[$];
    tcmd_t     m_cur;
    tcmd_t     m_in;
    int        m_t;
    int        m_len;
    bit        m_valid = 1'b0;
    bit        m_writing;
    int        m_size;
    bit        e_sel, e_wr, e_done, e_carry;
    bit [1:0]  e_op;
    bit [2:0]  e_rd_a, e_rd_b, e_wr_addr;
    bit [15:0] e_d_in;
    bit [15:0] e_retired;

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            m_q.delete();
            m_t = 0; m_len = 0;
            e_sel = 0; e_wr = 0; e_done = 0; e_carry = 0;
            e_op = 0; e_rd_a = 0; e_rd_b = 0; e_wr_addr = 0; e_d_in = 0;
            e_retired = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_writing = (m_t != 0) && (m_t == m_len);
            m_size    = m_q.size();
            if (e_done) e_retired = e_retired + 16'd1;
            e_done = m_writing;
            if (m_writing && m_cur.kind && dp_alu_cout) e_carry = 1'b1;
            else if (carry_clr)                        e_carry = 1'b0;
            if (m_t != 0) begin
                m_t = m_writing ? 0 : m_t + 1;
            end else if (m_size > 0) begin
                m_cur = m_q.pop_front();
                m_len = m_cur.kind ? 2 : 1;
                m_t   = 1;
            end
            if (cmd_valid && m_size < QDEPTH) begin
                m_in.kind = cmd_kind; m_in.op = cmd_op; m_in.a = cmd_a;
                m_in.b = cmd_b; m_in.dst = cmd_dst; m_in.imm = cmd_imm;
                m_q.push_back(m_in);
            end
            if (m_t != 0) begin
                e_wr_addr = m_cur.dst;
                e_sel     = m_cur.kind;
                if (m_cur.kind) begin
                    e_rd_a = m_cur.a;
                    e_rd_b = m_cur.b;
                    e_op   = m_cur.op;
                    e_wr   = (m_t == 2);
                end else begin
                    e_d_in = m_cur.imm;
                    e_wr   = 1'b1;
                end
            end else begin
                e_wr = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int done_seen = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_dp_wr",      dp_wr,        e_wr);
            check("cmp_dp_sel",     dp_sel,       e_sel);
            check("cmp_dp_op",      dp_op,        e_op);
            check("cmp_rd_addr_a",  dp_rd_addr_a, e_rd_a);
            check("cmp_rd_addr_b",  dp_rd_addr_b, e_rd_b);
            check("cmp_wr_addr",    dp_wr_addr,   e_wr_addr);
            check("cmp_d_in",       dp_d_in,      e_d_in);
            check("cmp_done",       done,         e_done);
            check("cmp_carry_flag", carry_flag,   e_carry);
            check("cmp_busy",       busy,         (m_t != 0) || (m_q.size() != 0));
            check("cmp_cmd_ready",  cmd_ready,    m_q.size() < QDEPTH);
`ifdef RETIRE_CNT_EN
            check("cmp_retired_cnt", retired_cnt, e_retired);
`endif
            if (done === 1'b1) done_seen++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus (inputs change on the falling edge)
    // ---------------------------------------------------------------------
    bit stall_seen = 1'b0;

    // Offers one command and returns on the falling edge after it was taken.
    // cmd_valid stays high so consecutive calls are back-to-back.
    task automatic push(input bit kind, input bit [1:0] op, input bit [2:0] a,
                        input bit [2:0] b, input bit [2:0] dst, input bit [15:0] imm);
        bit accepted;
        accepted  = 1'b0;
        cmd_kind  = kind;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_dst   = dst;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) accepted = 1'b1;
            else           stall_seen = 1'b1;
            @(negedge clk);
        end
        if (!accepted) check("push_timeout", cmd_ready, 1'b1);
    endtask

    int d0;

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_kind = 1'b0; cmd_op = '0;
        cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_imm = '0;
        dp_alu_cout = 1'b0; carry_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_dp_wr",     dp_wr,      1'b0);
        check("rst_busy",      busy,       1'b0);
        check("rst_cmd_ready", cmd_ready,  1'b1);
        check("rst_carry",     carry_flag, 1'b0);
        check("rst_d_in",      dp_d_in,    16'h0000);

        // LOAD r2 <- 0x1234
        push(1'b0, 2'b00, 3'd0, 3'd0, 3'd2, 16'h1234);
        cmd_valid = 1'b0;
        check("load_busy_queued", busy, 1'b1);
        @(negedge clk);
        check("load_wr",      dp_wr,      1'b1);
        check("load_sel",     dp_sel,     1'b0);
        check("load_wr_addr", dp_wr_addr, 3'd2);
        check("load_d_in",    dp_d_in,    16'h1234);
        check("load_no_done", done,       1'b0);
        @(negedge clk);
        check("load_done",    done,       1'b1);
        check("load_wr_off",  dp_wr,      1'b0);
        @(negedge clk);
        check("load_done_1cy", done,      1'b0);

        // ALU r5 = r2 op00 r3
        push(1'b1, 2'b00, 3'd2, 3'd3, 3'd5, 16'h0000);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("exec_rd_a",    dp_rd_addr_a, 3'd2);
        check("exec_rd_b",    dp_rd_addr_b, 3'd3);
        check("exec_wr",      dp_wr,        1'b0);
        check("exec_sel",     dp_sel,       1'b1);
        check("exec_wr_addr", dp_wr_addr,   3'd5);
        @(negedge clk);
        check("alu_wr",       dp_wr,        1'b1);
        check("alu_sel",      dp_sel,       1'b1);
        check("alu_wr_addr",  dp_wr_addr,   3'd5);
        check("alu_rd_a_hold", dp_rd_addr_a, 3'd2);
        check("alu_d_in_hold", dp_d_in,     16'h1234);
        @(negedge clk);
        check("alu_done",     done,         1'b1);

        // ALU r4 = r4 op01 r1 with carry out; flag must stick until cleared
        dp_alu_cout = 1'b1;
        push(1'b1, 2'b01, 3'd4, 3'd1, 3'd4, 16'h0000);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("carry_set",    carry_flag, 1'b1);
        dp_alu_cout = 1'b0;
        @(negedge clk);
        check("carry_held",   carry_flag, 1'b1);
        carry_clr = 1'b1;
        @(negedge clk);
        carry_clr = 1'b0;
        check("carry_cleared", carry_flag, 1'b0);

        // LOAD never sets the carry, even with the ALU carry-out high
        dp_alu_cout = 1'b1;
        push(1'b0, 2'b11, 3'd0, 3'd0, 3'd6, 16'hBEEF);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("load_no_carry", carry_flag, 1'b0);

        // Set and clear in the same cycle: set wins, then the clear applies
        carry_clr = 1'b1;
        push(1'b1, 2'b10, 3'd1, 3'd2, 3'd3, 16'h0000);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("carry_set_wins", carry_flag, 1'b1);
        @(negedge clk);
        check("carry_clr_after", carry_flag, 1'b0);
        carry_clr   = 1'b0;
        dp_alu_cout = 1'b0;

        // Burst of 7 ALU commands: FIFO fills, stalls, drains in order
        stall_seen = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 7; i++)
            push(1'b1, i[1:0], i[2:0], 3'(i + 1), 3'(6 - i), 16'h0000);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("burst_stalled", stall_seen, 1'b1);
        check("burst_dones",   done_seen - d0, 7);
        check("burst_idle",    busy, 1'b0);

        // Reset in the middle of a WRITE with a second command queued
        dp_alu_cout = 1'b1;
        push(1'b1, 2'b00, 3'd1, 3'd2, 3'd7, 16'h0000);
        push(1'b1, 2'b01, 3'd3, 3'd4, 3'd0, 16'h0000);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_write", dp_wr, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_wr",    dp_wr,      1'b0);
        check("midrst_busy",  busy,       1'b0);
        check("midrst_carry", carry_flag, 1'b0);
        check("midrst_ready", cmd_ready,  1'b1);
        reset = 1'b1;
        dp_alu_cout = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_dropped_wr",   dp_wr, 1'b0);
        check("midrst_dropped_busy", busy,  1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
